// File: rtl/uart_prog_loader_pkg.sv
// Shared definitions for the UART program loader.
// Sync byte, address width and FSM encodings.
package uart_prog_loader_pkg;

  localparam logic [7:0] UPG_SYNC_BYTE = 8'hA5;
  localparam int         UPG_ADR_W     = 14;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNT_L,
    S_CNT_H,
    S_PAYLOAD,
    S_CKSUM,
    S_DONE,
    S_ERR
  } upg_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

endpackage

// File: rtl/uart_prog_loader_rx.sv
// 8N1 UART receiver: synchronizer, bit timer, shift register.
// Emits one-cycle byte_valid or frame_err after the stop-bit sample.
module uart_rx_byte
  import uart_prog_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 86
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rx,
  output logic       o_byte_valid,
  output logic [7:0] o_byte_data,
  output logic       o_frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  logic          r_s1;
  logic          r_s2;
  rx_state_e     r_state;
  rx_state_e     w_next;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_valid;
  logic          r_ferr;
  logic          w_half;
  logic          w_full;

  assign w_half = (r_cnt == HALF);
  assign w_full = (r_cnt == FULL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
    end else begin
      r_s1 <= i_rx;
      r_s2 <= r_s1;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      RX_IDLE:  if (!r_s2) w_next = RX_START;
      RX_START: if (w_half) w_next = r_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_full && r_bit == 3'd7) w_next = RX_STOP;
      RX_STOP:  if (w_full) w_next = RX_IDLE;
      default:  w_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RX_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      if (r_state == RX_IDLE || w_next != r_state || w_full)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + CW'(1);
      if (r_state == RX_DATA && w_full) begin
        r_shift <= {r_s2, r_shift[7:1]};
        r_bit   <= r_bit + 3'd1;
      end
      if (r_state == RX_STOP && w_full) begin
        r_valid <= r_s2;
        r_ferr  <= !r_s2;
      end
    end
  end

  assign o_byte_valid = r_valid;
  assign o_byte_data  = r_shift;
  assign o_frame_err  = r_ferr;

endmodule

// File: rtl/uart_prog_loader.sv
// Framed UART program loader driving the I-cache UPG port.
// Define UPG_CHECKSUM_EN to require the trailing XOR checksum byte.
module uart_prog_loader
  import uart_prog_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 86,
  parameter int MAX_WORDS    = 16384
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic                 upg_rst,
  output logic                 upg_wen,
  output logic [UPG_ADR_W-1:0] upg_adr,
  output logic [31:0]          upg_dat,
  output logic                 upg_done,
  output logic                 upg_err
);

  localparam logic [15:0] MAXW = 16'(MAX_WORDS);
`ifdef UPG_CHECKSUM_EN
  localparam upg_state_e S_TAIL = S_CKSUM;
`else
  localparam upg_state_e S_TAIL = S_DONE;
`endif

  logic                 w_bv;
  logic [7:0]           w_byte;
  logic                 w_ferr;
  upg_state_e           r_state;
  upg_state_e           w_next;
  logic [15:0]          r_cnt;
  logic [15:0]          w_n;
  logic [1:0]           r_lane;
  logic [23:0]          r_word;
  logic                 r_wen;
  logic [UPG_ADR_W-1:0] r_adr;
  logic [31:0]          r_dat;
  logic                 w_active;
  logic                 w_last;
`ifdef UPG_CHECKSUM_EN
  logic [7:0]           r_ck;
`endif

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk         (clk),
    .rst         (rst),
    .i_rx        (rx),
    .o_byte_valid(w_bv),
    .o_byte_data (w_byte),
    .o_frame_err (w_ferr)
  );

  assign w_n      = {w_byte, r_cnt[7:0]};
  assign w_last   = (16'(r_adr) == r_cnt - 16'd1);
  assign w_active = !(r_state inside {S_IDLE, S_DONE, S_ERR});

  always_comb begin
    w_next = r_state;
    if (w_ferr && w_active) begin
      w_next = S_ERR;
    end else if (w_bv) begin
      unique case (r_state)
        S_IDLE, S_DONE, S_ERR:
          if (w_byte == UPG_SYNC_BYTE) w_next = S_CNT_L;
        S_CNT_L: w_next = S_CNT_H;
        S_CNT_H:
          if (w_n == 16'd0)     w_next = S_TAIL;
          else if (w_n > MAXW)  w_next = S_ERR;
          else                  w_next = S_PAYLOAD;
        S_PAYLOAD:
          if (r_lane == 2'd3 && w_last) w_next = S_TAIL;
`ifdef UPG_CHECKSUM_EN
        S_CKSUM: w_next = (w_byte == r_ck) ? S_DONE : S_ERR;
`endif
        default: w_next = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_lane <= '0;
      r_word <= '0;
      r_wen  <= 1'b0;
      r_adr  <= '0;
      r_dat  <= '0;
`ifdef UPG_CHECKSUM_EN
      r_ck   <= '0;
`endif
    end else begin
      r_wen <= 1'b0;
      if (r_wen) r_adr <= r_adr + UPG_ADR_W'(1);
      if (w_bv) begin
        unique case (r_state)
          S_IDLE, S_DONE, S_ERR:
            if (w_byte == UPG_SYNC_BYTE) begin
              r_adr  <= '0;
              r_lane <= '0;
`ifdef UPG_CHECKSUM_EN
              r_ck   <= '0;
`endif
            end
          S_CNT_L: r_cnt[7:0]  <= w_byte;
          S_CNT_H: r_cnt[15:8] <= w_byte;
          S_PAYLOAD: begin
            r_lane <= r_lane + 2'd1;
`ifdef UPG_CHECKSUM_EN
            r_ck   <= r_ck ^ w_byte;
`endif
            unique case (r_lane)
              2'd0: r_word[7:0]   <= w_byte;
              2'd1: r_word[15:8]  <= w_byte;
              2'd2: r_word[23:16] <= w_byte;
              default: begin
                r_dat <= {w_byte, r_word};
                r_wen <= 1'b1;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

  assign upg_rst  = !w_active;
  assign upg_done = (r_state == S_DONE);
  assign upg_err  = (r_state == S_ERR);
  assign upg_wen  = r_wen;
  assign upg_adr  = r_adr;
  assign upg_dat  = r_dat;

endmodule
